// File: rtl/ctrl_pipeline_pkg.sv
// Shared types and constants for the control pipeline: forwarding select
// encodings, the per-stage control bundle and the forwarding priority rule.
package ctrl_pipeline_pkg;

  // Register-index width carried in the stage bundle. It must match the
  // REG_W parameter of ctrl_pipeline.
  localparam int DEST_W = 5;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Control bundle carried by the EX stage register
  typedef struct packed {
    logic              valid;
    logic [2:0]        alu_op;
    logic              reg_write;
    logic              branch_inst;
    logic              alu_src;
    logic              mem_read;
    logic [DEST_W-1:0] dest;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_BUBBLE = '0;

  // Operand source for one EX register read. MEM holds the younger result,
  // so it wins over WB when both write the same register.
  function automatic logic [1:0] fwd_select(
    input logic              mem_wr,
    input logic [DEST_W-1:0] mem_dest,
    input logic              wb_wr,
    input logic [DEST_W-1:0] wb_dest,
    input logic [DEST_W-1:0] src
  );
    if (mem_wr && (mem_dest == src)) return FWD_MEM;
    if (wb_wr && (wb_dest == src))   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_sat_counter.sv
// Saturating up-counter for pipeline event statistics. Counts one per cycle
// with inc high, sticks at all-ones, clears on synchronous reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  // Count events, holding once every bit is set
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, regardless of block evaluation order.
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: carries decoded controls from ID through EX, MEM and WB,
// detects load-use hazards, squashes on taken branches, selects EX operand
// forwarding and counts stall/flush events.
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = DEST_W
) (
  input  logic             clk,
  input  logic             rst_n,
  // Decode stage
  input  logic             id_valid,
  input  logic [2:0]       id_ALUop,
  input  logic             id_RegWrite,
  input  logic             id_branch_inst,
  input  logic             id_RegDest,
  input  logic             id_ALUsrc,
  input  logic             id_mem_read,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_branch_taken,
  // Hazard control
  output logic             stall,
  output logic             flush_ifid,
  // EX stage
  output logic             ex_valid,
  output logic [2:0]       ex_ALUop,
  output logic             ex_RegWrite,
  output logic             ex_branch_inst,
  output logic             ex_ALUsrc,
  output logic             ex_mem_read,
  output logic [REG_W-1:0] ex_dest,
  // MEM / WB stages
  output logic [REG_W-1:0] mem_dest,
  output logic [REG_W-1:0] wb_dest,
  output logic             mem_valid,
  output logic             mem_RegWrite,
  output logic             mem_mem_read,
  output logic             wb_valid,
  output logic             wb_RegWrite,
  // Forwarding and statistics
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Stage registers
  stage_ctrl_t      r_ex;
  logic [REG_W-1:0] r_ex_rs;
  logic [REG_W-1:0] r_ex_rt;

  logic             r_mem_valid;
  logic             r_mem_reg_write;
  logic             r_mem_mem_read;
  logic [REG_W-1:0] r_mem_dest;

  logic             r_wb_valid;
  logic             r_wb_reg_write;
  logic [REG_W-1:0] r_wb_dest;

  // Decode-side helpers
  logic [REG_W-1:0] w_id_dest;
  logic             w_id_reads_rt;
  logic             w_load_use;
  logic             w_flush;
  logic             w_stall;
  logic             w_ex_bubble;
  logic             w_mem_wr;
  logic             w_wb_wr;

  assign w_id_dest     = id_RegDest ? id_rd : id_rt;
  // rt is a source unless it is overwritten by an immediate; branches compare it
  assign w_id_reads_rt = !id_ALUsrc || id_branch_inst;

  // A load in EX cannot forward to the instruction behind it in time
  assign w_load_use = id_valid && r_ex.valid && r_ex.mem_read &&
                      (r_ex.dest != '0) &&
                      ((r_ex.dest == id_rs) ||
                       (w_id_reads_rt && (r_ex.dest == id_rt)));

  assign w_flush     = r_ex.valid && r_ex.branch_inst && ex_branch_taken;
  // A taken branch squashes the ID instruction anyway, so it overrides the stall
  assign w_stall     = w_load_use && !w_flush;
  assign w_ex_bubble = w_flush || w_stall || !id_valid;

  assign stall      = w_stall;
  assign flush_ifid = w_flush;

  // Register 0 is hard-wired, so writes to it never count as producers
  assign w_mem_wr = r_mem_valid && r_mem_reg_write && (r_mem_dest != '0);
  assign w_wb_wr  = r_wb_valid && r_wb_reg_write && (r_wb_dest != '0);

  assign fwd_a = r_ex.valid ? fwd_select(w_mem_wr, r_mem_dest, w_wb_wr, r_wb_dest, r_ex_rs)
                            : FWD_RF;
  assign fwd_b = r_ex.valid ? fwd_select(w_mem_wr, r_mem_dest, w_wb_wr, r_wb_dest, r_ex_rt)
                            : FWD_RF;

  // ID -> EX: latch decoded controls, or insert a bubble on flush/stall/empty ID
  always_ff @(posedge clk) begin
    if (!rst_n || w_ex_bubble) begin
      r_ex    <= STAGE_BUBBLE;
      r_ex_rs <= '0;
      r_ex_rt <= '0;
    end else begin
      r_ex.valid       <= 1'b1;
      r_ex.alu_op      <= id_ALUop;
      r_ex.reg_write   <= id_RegWrite;
      r_ex.branch_inst <= id_branch_inst;
      r_ex.alu_src     <= id_ALUsrc;
      r_ex.mem_read    <= id_mem_read;
      r_ex.dest        <= w_id_dest;
      r_ex_rs          <= id_rs;
      r_ex_rt          <= id_rt;
    end
  end

  // EX -> MEM -> WB: unconditional advance, no backpressure past EX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_valid     <= 1'b0;
      r_mem_reg_write <= 1'b0;
      r_mem_mem_read  <= 1'b0;
      r_mem_dest      <= '0;
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_dest       <= '0;
    end else begin
      r_mem_valid     <= r_ex.valid;
      r_mem_reg_write <= r_ex.reg_write;
      r_mem_mem_read  <= r_ex.mem_read;
      r_mem_dest      <= r_ex.dest;
      r_wb_valid      <= r_mem_valid;
      r_wb_reg_write  <= r_mem_reg_write;
      r_wb_dest       <= r_mem_dest;
    end
  end

  assign ex_valid       = r_ex.valid;
  assign ex_ALUop       = r_ex.alu_op;
  assign ex_RegWrite    = r_ex.reg_write;
  assign ex_branch_inst = r_ex.branch_inst;
  assign ex_ALUsrc      = r_ex.alu_src;
  assign ex_mem_read    = r_ex.mem_read;
  assign ex_dest        = r_ex.dest;

  assign mem_valid    = r_mem_valid;
  assign mem_RegWrite = r_mem_reg_write;
  assign mem_mem_read = r_mem_mem_read;
  assign mem_dest     = r_mem_dest;
  assign wb_valid     = r_wb_valid;
  assign wb_RegWrite  = r_wb_reg_write;
  assign wb_dest      = r_wb_dest;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush),
    .count (flush_cnt)
  );

endmodule
